// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the loader.
// Carries no state; timing is set entirely by the loader.
// rx_valid/rx_ready handshake; the memory side has no backpressure.
interface imem_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        core_hold;

    // Loader side
    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, core_hold
    );

    // Host/bench side
    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, core_hold
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory, holding the core meanwhile.
// Latency: last byte of a word at edge k -> mem_we in cycle k+1; last word -> done in cycle k+2.
// Backpressure: rx_ready drops for the single WRITE cycle and outside LEN_HI/LEN_LO/DATA.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t      state;
    logic [15:0] len;
    logic [15:0] idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;

    logic        accept;
    logic [15:0] len_next;
    logic [15:0] idx_inc;
    logic [31:0] wr_addr;
    logic        len_too_big;

    // A byte moves only when both sides agree; rx_ready already encodes the state.
    assign accept      = bus.rx_valid & bus.rx_ready;
    assign len_next    = {len[15:8], bus.rx_data};
    assign idx_inc     = idx + 16'd1;
    // Word index scaled to bytes; wraps modulo 2^32 by construction.
    assign wr_addr     = BASE_ADDR + {14'd0, idx, 2'b00};
    assign len_too_big = 32'(len_next) > MAX_WORDS;

    // Session FSM: state, datapath and all outputs are registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            len           <= 16'd0;
            idx           <= 16'd0;
            byte_cnt      <= 2'd0;
            shift         <= 24'd0;
            bus.rx_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.core_hold <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        state         <= LEN_HI;
                        idx           <= 16'd0;
                        byte_cnt      <= 2'd0;
                        bus.rx_ready  <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.done      <= 1'b0;
                        bus.err       <= 1'b0;
                        bus.core_hold <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= bus.rx_data;
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len <= len_next;
                        if (len_next == 16'd0) begin
                            // Empty program: nothing to write, release the core at once.
                            state         <= DONE;
                            bus.rx_ready  <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                            bus.core_hold <= 1'b0;
                        end else if (len_too_big) begin
                            // Oversized program: keep the core frozen, memory untouched.
                            state        <= ERROR;
                            bus.rx_ready <= 1'b0;
                            bus.busy     <= 1'b0;
                            bus.err      <= 1'b1;
                        end else begin
                            state    <= DATA;
                            byte_cnt <= 2'd0;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Fourth byte completes the word; present it straight to memory.
                            state         <= WRITE;
                            bus.rx_ready  <= 1'b0;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= wr_addr;
                            bus.mem_wdata <= {shift, bus.rx_data};
                        end else begin
                            shift <= {shift[15:0], bus.rx_data};
                        end
                    end
                end
                WRITE: begin
                    bus.mem_we <= 1'b0;
                    idx        <= idx_inc;
                    if (idx_inc == len) begin
                        state         <= DONE;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.core_hold <= 1'b0;
                    end else begin
                        state        <= DATA;
                        byte_cnt     <= 2'd0;
                        bus.rx_ready <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.rx_ready  <= 1'b0;
                    bus.mem_we    <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.done      <= 1'b0;
                    bus.err       <= 1'b0;
                    bus.core_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule
